// File: rtl/broadcast_pkg.sv
// Shared types and constants for the serial broadcast line controller.
package broadcast_pkg;

    localparam int HDR_BITS  = 3;
    localparam int NUM_LINES = 4;

    typedef logic [1:0] lineAddrT;

    typedef enum logic [2:0] {
        IDLE,
        HDR,
        DATA,
        STOP,
        RECOVER
    } bcastStateT;

endpackage

// File: rtl/serial_shift_reg.sv
// MSB-first serial-in shift register holding the frame payload.
module serial_shift_reg #(
    parameter int DATA_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              shiftEn,
    input  logic              serIn,
    output logic [DATA_W-1:0] q
);

    // Shift left so the first bit received ends up in the MSB.
    always_ff @(posedge clk) begin
        if (rst) begin
            q <= '0;
        end else if (shiftEn) begin
            q <= DATA_W'({q, serIn});
        end
    end

endmodule

// File: rtl/serial_broadcast_ctrl.sv
// Serial frame receiver that loads one addressed line register, or all
// four on a broadcast frame, once a valid stop bit has been sampled.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | line idle high, waiting for a start bit (0)
// HDR     | capturing bcast, addr[1], addr[0]
// DATA    | shifting in DATA_W payload bits, MSB first
// STOP    | checking the stop bit; commit on 1, reject on 0
// RECOVER | rejected frame, waiting for the line to return high
module serial_broadcast_ctrl
    import broadcast_pkg::*;
#(
    parameter int DATA_W = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 serIn,
    output logic [DATA_W-1:0]    L0,
    output logic [DATA_W-1:0]    L1,
    output logic [DATA_W-1:0]    L2,
    output logic [DATA_W-1:0]    L3,
    output logic [NUM_LINES-1:0] lineValid,
    output logic                 busy,
    output logic                 frameErr
);

    localparam int MAX_CNT = (DATA_W > HDR_BITS) ? DATA_W : HDR_BITS;
    localparam int CNT_W   = $clog2(MAX_CNT);

    bcastStateT          state;
    bcastStateT          stateNext;
    logic [CNT_W-1:0]    bitCnt;
    logic [CNT_W-1:0]    bitCntNext;
    logic                hdrEn;
    logic                shiftEn;
    logic                commit;
    logic                badStop;
    logic [HDR_BITS-1:0] hdrReg;
    logic [DATA_W-1:0]   payload;
    logic [DATA_W-1:0]   lineReg [NUM_LINES];
    logic                bcast;
    lineAddrT            addr;

    assign bcast = hdrReg[2];
    assign addr  = lineAddrT'(hdrReg[1:0]);

    assign L0 = lineReg[0];
    assign L1 = lineReg[1];
    assign L2 = lineReg[2];
    assign L3 = lineReg[3];

    serial_shift_reg #(
        .DATA_W (DATA_W)
    ) uShiftReg (
        .clk     (clk),
        .rst     (rst),
        .shiftEn (shiftEn),
        .serIn   (serIn),
        .q       (payload)
    );

    // State and bit down-counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            bitCnt <= '0;
        end else begin
            state  <= stateNext;
            bitCnt <= bitCntNext;
        end
    end

    // Next-state decode; the counter is loaded with (bits - 1) on entry to
    // HDR/DATA and the phase ends on its terminal count of zero.
    always_comb begin
        stateNext  = state;
        bitCntNext = bitCnt;
        hdrEn      = 1'b0;
        shiftEn    = 1'b0;
        commit     = 1'b0;
        badStop    = 1'b0;
        case (state)
            IDLE: begin
                if (!serIn) begin
                    stateNext  = HDR;
                    bitCntNext = CNT_W'(HDR_BITS - 1);
                end
            end
            HDR: begin
                hdrEn = 1'b1;
                if (bitCnt == '0) begin
                    stateNext  = DATA;
                    bitCntNext = CNT_W'(DATA_W - 1);
                end else begin
                    bitCntNext = bitCnt - 1'b1;
                end
            end
            DATA: begin
                shiftEn = 1'b1;
                if (bitCnt == '0) begin
                    stateNext = STOP;
                end else begin
                    bitCntNext = bitCnt - 1'b1;
                end
            end
            STOP: begin
                if (serIn) begin
                    commit    = 1'b1;
                    stateNext = IDLE;
                end else begin
                    badStop   = 1'b1;
                    stateNext = RECOVER;
                end
            end
            RECOVER: begin
                if (serIn) begin
                    stateNext = IDLE;
                end
            end
            default: begin
                stateNext = IDLE;
            end
        endcase
    end

    // Header capture, line registers and registered strobes/busy flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            hdrReg    <= '0;
            lineValid <= '0;
            frameErr  <= 1'b0;
            busy      <= 1'b0;
            for (int i = 0; i < NUM_LINES; i++) begin
                lineReg[i] <= '0;
            end
        end else begin
            lineValid <= '0;
            frameErr  <= badStop;
            busy      <= (stateNext != IDLE);
            if (hdrEn) begin
                hdrReg <= {hdrReg[HDR_BITS-2:0], serIn};
            end
            if (commit) begin
                for (int i = 0; i < NUM_LINES; i++) begin
                    if (bcast || (addr == lineAddrT'(i))) begin
                        lineReg[i]   <= payload;
                        lineValid[i] <= 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_serial_broadcast_ctrl.sv
// Self-checking bench for serial_broadcast_ctrl: directed and random frames
// are scored against a frame-level model of the line registers.
module tb_serial_broadcast_ctrl;

    localparam int DATA_W = 4;

    typedef struct {
        int   stamp;
        logic busy;
    } busyExpT;

    typedef struct {
        int                stamp;
        logic              err;
        logic [3:0]        lv;
        logic [DATA_W-1:0] l0;
        logic [DATA_W-1:0] l1;
        logic [DATA_W-1:0] l2;
        logic [DATA_W-1:0] l3;
    } outExpT;

    logic              clk   = 1'b0;
    logic              rst   = 1'b1;
    logic              serIn = 1'b1;
    logic [DATA_W-1:0] L0;
    logic [DATA_W-1:0] L1;
    logic [DATA_W-1:0] L2;
    logic [DATA_W-1:0] L3;
    logic [3:0]        lineValid;
    logic              busy;
    logic              frameErr;

    int cyc    = 0;
    int checks = 0;
    int errors = 0;

    logic [DATA_W-1:0] modelLine [4];
    busyExpT           busyQ [$];
    outExpT            outQ [$];

    serial_broadcast_ctrl #(
        .DATA_W (DATA_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .serIn     (serIn),
        .L0        (L0),
        .L1        (L1),
        .L2        (L2),
        .L3        (L3),
        .lineValid (lineValid),
        .busy      (busy),
        .frameErr  (frameErr)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Drive one bit for the next sampling edge and record the busy level
    // expected after that edge.
    task automatic driveBit(input logic b, input logic expBusy, output int stamp);
        busyExpT e;
        @(negedge clk);
        rst     = 1'b0;
        serIn   = b;
        stamp   = cyc + 1;
        e.stamp = stamp;
        e.busy  = expBusy;
        busyQ.push_back(e);
    endtask

    task automatic idleBits(input int n);
        int st;
        for (int k = 0; k < n; k++) driveBit(1'b1, 1'b0, st);
    endtask

    task automatic sendFrame(input logic bc, input logic [1:0] addr,
                             input logic [DATA_W-1:0] data, input logic stopOk,
                             input int recoverLow);
        int         st;
        outExpT     e;
        logic [3:0] mask;
        driveBit(1'b0, 1'b1, st);
        driveBit(bc, 1'b1, st);
        driveBit(addr[1], 1'b1, st);
        driveBit(addr[0], 1'b1, st);
        for (int i = DATA_W - 1; i >= 0; i--) driveBit(data[i], 1'b1, st);
        if (stopOk) begin
            driveBit(1'b1, 1'b0, st);
            mask = bc ? 4'b1111 : 4'(1 << addr);
            for (int i = 0; i < 4; i++) begin
                if (mask[i]) modelLine[i] = data;
            end
            e.err = 1'b0;
            e.lv  = mask;
        end else begin
            driveBit(1'b0, 1'b1, st);
            e.err = 1'b1;
            e.lv  = 4'b0000;
        end
        e.stamp = st;
        e.l0    = modelLine[0];
        e.l1    = modelLine[1];
        e.l2    = modelLine[2];
        e.l3    = modelLine[3];
        outQ.push_back(e);
        if (!stopOk) begin
            for (int k = 0; k < recoverLow; k++) driveBit(1'b0, 1'b1, st);
            driveBit(1'b1, 1'b0, st);
        end
    endtask

    task automatic doReset(input int n);
        busyExpT e;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            rst     = 1'b1;
            serIn   = 1'b1;
            e.stamp = cyc + 1;
            e.busy  = 1'b0;
            busyQ.push_back(e);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) modelLine[i] = '0;
        check("reset L0", 32'(L0), 32'(0));
        check("reset L1", 32'(L1), 32'(0));
        check("reset L2", 32'(L2), 32'(0));
        check("reset L3", 32'(L3), 32'(0));
        check("reset lineValid", 32'(lineValid), 32'(0));
        check("reset frameErr", 32'(frameErr), 32'(0));
        check("reset busy", 32'(busy), 32'(0));
        e.stamp = cyc + 1;
        e.busy  = 1'b0;
        busyQ.push_back(e);
    endtask

    // Monitor: compares busy per sampled bit and every strobe against the
    // scoreboard entry pushed when the frame was issued.
    always @(negedge clk) begin
        busyExpT be;
        outExpT  oe;
        if (busyQ.size() > 0 && busyQ[0].stamp == cyc) begin
            be = busyQ.pop_front();
            check("busy", 32'(busy), 32'(be.busy));
        end
        if (lineValid != 4'b0000 || frameErr) begin
            check("strobe exclusive", 32'(lineValid != 4'b0000 && frameErr), 32'(0));
            if (outQ.size() == 0) begin
                check("unexpected strobe", 32'(lineValid), 32'(0));
            end else begin
                oe = outQ.pop_front();
                check("strobe cycle", 32'(cyc), 32'(oe.stamp));
                check("lineValid", 32'(lineValid), 32'(oe.lv));
                check("frameErr", 32'(frameErr), 32'(oe.err));
                check("L0", 32'(L0), 32'(oe.l0));
                check("L1", 32'(L1), 32'(oe.l1));
                check("L2", 32'(L2), 32'(oe.l2));
                check("L3", 32'(L3), 32'(oe.l3));
            end
        end else if (outQ.size() > 0 && outQ[0].stamp <= cyc) begin
            oe = outQ.pop_front();
            check("missing strobe at cycle", 32'(cyc), 32'(oe.stamp + 1000000));
        end
    end

    initial begin
        #1000000;
        $display("FAIL timeout: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        int               st;
        logic             bc;
        logic [1:0]       addr;
        logic [DATA_W-1:0] data;
        logic             stopOk;

        for (int i = 0; i < 4; i++) modelLine[i] = '0;
        doReset(3);

        // Addressed load to line 2.
        sendFrame(1'b0, 2'd2, 4'b1011, 1'b1, 0);
        idleBits(2);
        // Broadcast.
        sendFrame(1'b1, 2'd0, 4'b0110, 1'b1, 0);
        idleBits(2);
        // Preload line 1, then a frame with a bad stop bit and held-low line.
        sendFrame(1'b0, 2'd1, 4'b0011, 1'b1, 0);
        idleBits(1);
        sendFrame(1'b0, 2'd1, 4'b1111, 1'b0, 5);
        idleBits(2);
        // Back-to-back frames, no idle bit between.
        sendFrame(1'b0, 2'd0, 4'b0001, 1'b1, 0);
        sendFrame(1'b0, 2'd3, 4'b1000, 1'b1, 0);
        idleBits(2);
        // Reset in the middle of DATA, then a fresh frame.
        driveBit(1'b0, 1'b1, st);
        driveBit(1'b0, 1'b1, st);
        driveBit(1'b0, 1'b1, st);
        driveBit(1'b1, 1'b1, st);
        driveBit(1'b1, 1'b1, st);
        driveBit(1'b0, 1'b1, st);
        doReset(1);
        sendFrame(1'b0, 2'd1, 4'b1010, 1'b1, 0);
        // Idle line.
        idleBits(20);

        // Random frames, occasional bad stop bits and back-to-back spacing.
        for (int n = 0; n < 60; n++) begin
            bc     = ($urandom_range(0, 3) == 0);
            addr   = 2'($urandom_range(0, 3));
            data   = DATA_W'($urandom);
            stopOk = ($urandom_range(0, 7) != 0);
            sendFrame(bc, addr, data, stopOk, int'($urandom_range(0, 4)));
            idleBits(int'($urandom_range(0, 2)));
        end

        idleBits(4);
        check("pending strobes", 32'(outQ.size()), 32'(0));
        check("final L0", 32'(L0), 32'(modelLine[0]));
        check("final L1", 32'(L1), 32'(modelLine[1]));
        check("final L2", 32'(L2), 32'(modelLine[2]));
        check("final L3", 32'(L3), 32'(modelLine[3]));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
